// File: rtl/dm_store_unit_if.sv
// Store request (M stage side) and data memory write port of dm_store_unit.
interface dm_store_unit_if #(
   parameter int unsigned DEPTH = 2
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic          M_req_valid;
   logic          M_req_ready;
   logic [31:0]   M_addr;
   logic [31:0]   M_wdata;
   logic [1:0]    M_storeOp;
   logic          M_alignErr;
   logic [CW-1:0] M_count;

   logic          mem_valid;
   logic          mem_ready;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_byteen;

   // The store unit itself.
   modport slave (
      input  M_req_valid, M_addr, M_wdata, M_storeOp, mem_ready,
      output M_req_ready, M_alignErr, M_count,
             mem_valid, mem_addr, mem_wdata, mem_byteen
   );

   // The pipeline and memory environment around it.
   modport master (
      output M_req_valid, M_addr, M_wdata, M_storeOp, mem_ready,
      input  M_req_ready, M_alignErr, M_count,
             mem_valid, mem_addr, mem_wdata, mem_byteen
   );
endinterface

// File: rtl/dm_store_unit.sv
// Store narrowing + in-order store buffer draining to data memory over valid/ready.
// Optional feature macro: ALIGN_CHECK_EN (drop misaligned/illegal stores and pulse M_alignErr).
module dm_store_unit #(
   parameter int unsigned DEPTH = 2
) (
   input  logic           clk,
   input  logic           reset,
   dm_store_unit_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("dm_store_unit: DEPTH must be a power of two and at least 2");
   end

   typedef struct packed {
      logic [29:0] addr_hi;
      logic [31:0] wdata;
      logic [3:0]  byteen;
   } entry_t;

   entry_t        buf_q [DEPTH];
   entry_t        new_entry_c;
   entry_t        head_c;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          ready_q,  valid_q;

   logic          misalign_c;
   logic          accept_c;
   logic          push_c;
   logic          pop_c;

   // Lane narrowing and byte-enable generation for the incoming request.
   always_comb begin
      new_entry_c         = '0;
      new_entry_c.addr_hi = bus.M_addr[31:2];
      misalign_c          = 1'b0;
      case (bus.M_storeOp)
         2'b00: begin
            new_entry_c.byteen = 4'b1111;
            new_entry_c.wdata  = bus.M_wdata;
`ifdef ALIGN_CHECK_EN
            misalign_c         = (bus.M_addr[1:0] != 2'b00);
`endif
         end
         2'b01: begin
            new_entry_c.byteen = bus.M_addr[1] ? 4'b1100 : 4'b0011;
            new_entry_c.wdata  = {2{bus.M_wdata[15:0]}};
`ifdef ALIGN_CHECK_EN
            misalign_c         = bus.M_addr[0];
`endif
         end
         2'b10: begin
            new_entry_c.byteen = 4'b0001 << bus.M_addr[1:0];
            new_entry_c.wdata  = {4{bus.M_wdata[7:0]}};
         end
         default: begin
            // Illegal op: becomes a no-op write unless it is rejected.
            new_entry_c.byteen = 4'b0000;
            new_entry_c.wdata  = bus.M_wdata;
`ifdef ALIGN_CHECK_EN
            misalign_c         = 1'b1;
`endif
         end
      endcase
   end

   assign accept_c = bus.M_req_valid && ready_q;
   assign push_c   = accept_c && !misalign_c;
   assign pop_c    = valid_q && bus.mem_ready;

   // Pointer and occupancy next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_c) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push_c && !pop_c) begin
         count_d = count_q + CW'(1);
      end else if (!push_c && pop_c) begin
         count_d = count_q - CW'(1);
      end
   end

   // Ready/valid flags are registered copies of the next occupancy, so no pop bypass.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ready_q  <= (count_d != CW'(DEPTH));
         valid_q  <= (count_d != '0);
      end
   end

   // Entry storage; contents are only observable through the valid-gated outputs.
   always_ff @(posedge clk) begin
      if (push_c) begin
         buf_q[wr_ptr_q] <= new_entry_c;
      end
   end

`ifdef ALIGN_CHECK_EN
   logic align_err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         align_err_q <= 1'b0;
      end else begin
         align_err_q <= accept_c && misalign_c;
      end
   end

   assign bus.M_alignErr = align_err_q;
`else
   assign bus.M_alignErr = 1'b0;
`endif

   assign head_c          = buf_q[rd_ptr_q];

   assign bus.M_req_ready = ready_q;
   assign bus.M_count     = count_q;
   assign bus.mem_valid   = valid_q;
   assign bus.mem_addr    = valid_q ? {head_c.addr_hi, 2'b00} : 32'h0;
   assign bus.mem_wdata   = valid_q ? head_c.wdata : 32'h0;
   assign bus.mem_byteen  = valid_q ? head_c.byteen : 4'h0;
endmodule
